// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst master state type.
package axi_pkg;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [3:0]  STRB_ALL    = 4'hF;
  localparam logic [13:0] PAGE_BYTES  = 14'd4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } burst_state_t;

  // A burst of (len+1) 4-byte beats starting at page offset 'offset' must end
  // at or before the 4 KB page boundary; AXI forbids bursts that cross it.
  function automatic logic crossesPage(input logic [11:0] offset, input logic [7:0] len);
    logic [13:0] endOffset;
    endOffset = {2'b00, offset} + (({6'b000000, len} + 14'd1) << 2);
    return (endOffset > PAGE_BYTES);
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: accepts a client command, runs
// one write or read burst, streams data straight through, and reports
// completion with a one-cycle done pulse and an accumulated error flag.
module axi_burst_master
  import axi_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETn,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,

  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,

  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,

  output logic        done,
  output logic        err,

  output logic        AWID,
  output logic [31:0] AWADDR,
  output logic [7:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,

  output logic        WID,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,

  input  logic        BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,

  output logic        ARID,
  output logic [31:0] ARADDR,
  output logic [7:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,

  input  logic        RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY
);

  burst_state_t r_state;
  burst_state_t w_nextState;

  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_beatCnt;
  logic        r_err;
  logic        r_done;

  logic w_badCmd;
  logic w_lastBeat;
  logic w_cmdFire;
  logic w_wBeat;
  logic w_rBeat;
  logic w_bFire;
  logic w_rBeatErr;
  logic w_unusedIds;

  // IDs are fixed at zero with one transaction outstanding, so response IDs carry no information.
  assign w_unusedIds = BID ^ RID;

  assign w_badCmd   = (cmd_addr[1:0] != 2'b00) || crossesPage(cmd_addr[11:0], cmd_len);
  assign w_lastBeat = (r_beatCnt == r_len);
  assign w_rBeatErr = (RRESP != RESP_OKAY) || (RLAST != w_lastBeat);

  assign AWID    = 1'b0;
  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWSIZE  = SIZE_4B;
  assign AWBURST = BURST_INCR;
  assign WID     = 1'b0;
  assign WSTRB   = STRB_ALL;
  assign ARID    = 1'b0;
  assign ARADDR  = r_addr;
  assign ARLEN   = r_len;
  assign ARSIZE  = SIZE_4B;
  assign ARBURST = BURST_INCR;

  assign done = r_done;
  assign err  = r_done & r_err;

  // State register; reset abandons any burst in progress without a done pulse.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and handshake outputs; data paths pass straight through in their phase.
  always_comb begin
    w_nextState = r_state;
    cmd_ready   = 1'b0;
    AWVALID     = 1'b0;
    WVALID      = 1'b0;
    WDATA       = 32'h0;
    WLAST       = 1'b0;
    wr_ready    = 1'b0;
    BREADY      = 1'b0;
    ARVALID     = 1'b0;
    RREADY      = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = 32'h0;
    rd_last     = 1'b0;
    w_cmdFire   = 1'b0;
    w_wBeat     = 1'b0;
    w_rBeat     = 1'b0;
    w_bFire     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_cmdFire = 1'b1;
          if (!w_badCmd) begin
            w_nextState = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
          end
        end
      end

      ST_WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) begin
          w_nextState = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        WVALID   = wr_valid;
        WDATA    = wr_data;
        WLAST    = w_lastBeat;
        wr_ready = WREADY;
        if (wr_valid && WREADY) begin
          w_wBeat = 1'b1;
          if (w_lastBeat) begin
            w_nextState = ST_WR_RESP;
          end
        end
      end

      ST_WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID) begin
          w_bFire     = 1'b1;
          w_nextState = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) begin
          w_nextState = ST_RD_DATA;
        end
      end

      ST_RD_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = w_lastBeat;
        if (RVALID && rd_ready) begin
          w_rBeat = 1'b1;
          if (w_lastBeat) begin
            w_nextState = ST_IDLE;
          end
        end
      end

      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Command latch, beat counter and error/done bookkeeping; the beat counter, not RLAST, ends a read.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_addr    <= 32'h0;
      r_len     <= 8'h0;
      r_beatCnt <= 8'h0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cmdFire) begin
        r_addr    <= cmd_addr;
        r_len     <= cmd_len;
        r_beatCnt <= 8'h0;
        r_err     <= w_badCmd;
        r_done    <= w_badCmd;
      end
      if (w_wBeat) begin
        r_beatCnt <= r_beatCnt + 8'd1;
      end
      if (w_bFire) begin
        r_err  <= r_err | (BRESP != RESP_OKAY);
        r_done <= 1'b1;
      end
      if (w_rBeat) begin
        r_beatCnt <= r_beatCnt + 8'd1;
        r_err     <= r_err | w_rBeatErr;
        r_done    <= w_lastBeat;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: a table of burst commands driven
// through a cycle-exact slave model, plus hand sequences for reset
// mid-burst and back-to-back commands.
module tb_axi_burst_master;
  import axi_pkg::*;

  logic        ACLK;
  logic        ARESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        done;
  logic        err;
  logic        AWID;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic        WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic        BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic        RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        isWrite;
    logic [31:0] addr;
    logic [7:0]  len;
    int          addrDelay;
    int          errBeat;
    int          lastBeat;
    logic        toggle;
    logic [1:0]  bresp;
    logic        expReject;
    logic        expErr;
  } vec_t;

  vec_t vecs[9];

  axi_burst_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  // 100 MHz-style free-running clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Safety net so a wedged run still ends with a report
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared %0d", nCompared);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present a command for one cycle; IDLE must be accepting
  task automatic offerCmd(input logic isWrite, input logic [31:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = isWrite;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    checkOutput("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Address phase: VALID must be held, with stable fields, until READY after 'delay' cycles
  task automatic addrPhase(input logic isWrite, input logic [31:0] addr, input logic [7:0] len, input int delay);
    for (int d = 0; d <= delay; d++) begin
      if (isWrite) AWREADY = (d == delay);
      else         ARREADY = (d == delay);
      #1;
      if (isWrite) begin
        checkOutput("AWVALID", {31'b0, AWVALID}, 32'd1);
        checkOutput("AWADDR", AWADDR, addr);
        checkOutput("AWLEN", {24'b0, AWLEN}, {24'b0, len});
        checkOutput("AWSIZE", {29'b0, AWSIZE}, 32'd2);
        checkOutput("AWBURST", {30'b0, AWBURST}, 32'd1);
        checkOutput("ARVALID_in_wr", {31'b0, ARVALID}, 32'd0);
      end else begin
        checkOutput("ARVALID", {31'b0, ARVALID}, 32'd1);
        checkOutput("ARADDR", ARADDR, addr);
        checkOutput("ARLEN", {24'b0, ARLEN}, {24'b0, len});
        checkOutput("ARSIZE", {29'b0, ARSIZE}, 32'd2);
        checkOutput("ARBURST", {30'b0, ARBURST}, 32'd1);
        checkOutput("AWVALID_in_rd", {31'b0, AWVALID}, 32'd0);
      end
      checkOutput("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      checkOutput("done_busy", {31'b0, done}, 32'd0);
      tick();
    end
    AWREADY = 1'b0;
    ARREADY = 1'b0;
  endtask

  // Write beats 0xA0+b; optional client stall cycle before each odd beat
  task automatic writeData(input logic [7:0] len, input logic toggle);
    for (int b = 0; b <= int'(len); b++) begin
      if (toggle && (b % 2 == 1)) begin
        wr_valid = 1'b0;
        WREADY   = 1'b1;
        #1;
        checkOutput("WVALID_stall", {31'b0, WVALID}, 32'd0);
        tick();
      end
      wr_valid = 1'b1;
      wr_data  = 32'hA0 + 32'(b);
      WREADY   = 1'b1;
      #1;
      checkOutput("WVALID", {31'b0, WVALID}, 32'd1);
      checkOutput("WDATA", WDATA, 32'hA0 + 32'(b));
      checkOutput("WLAST", {31'b0, WLAST}, {31'b0, (b == int'(len))});
      checkOutput("WSTRB", {28'b0, WSTRB}, 32'hF);
      checkOutput("wr_ready", {31'b0, wr_ready}, 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    WREADY   = 1'b0;
  endtask

  task automatic writeResp(input logic [1:0] bresp);
    BVALID = 1'b1;
    BRESP  = bresp;
    #1;
    checkOutput("BREADY", {31'b0, BREADY}, 32'd1);
    checkOutput("WVALID_after", {31'b0, WVALID}, 32'd0);
    tick();
    BVALID = 1'b0;
    BRESP  = RESP_OKAY;
  endtask

  // Read beats 0xD0000000+b; RLAST driven on 'lastBeat', SLVERR on 'errBeat'
  task automatic readData(input logic [7:0] len, input int errBeat, input int lastBeat, input logic toggle);
    for (int b = 0; b <= int'(len); b++) begin
      RVALID = 1'b1;
      RDATA  = 32'hD000_0000 + 32'(b);
      RRESP  = (b == errBeat) ? RESP_SLVERR : RESP_OKAY;
      RLAST  = (b == lastBeat);
      if (toggle && (b % 2 == 1)) begin
        rd_ready = 1'b0;
        #1;
        checkOutput("rd_valid_stall", {31'b0, rd_valid}, 32'd1);
        checkOutput("RREADY_stall", {31'b0, RREADY}, 32'd0);
        tick();
      end
      rd_ready = 1'b1;
      #1;
      checkOutput("RREADY", {31'b0, RREADY}, 32'd1);
      checkOutput("rd_data", rd_data, 32'hD000_0000 + 32'(b));
      checkOutput("rd_last", {31'b0, rd_last}, {31'b0, (b == int'(len))});
      checkOutput("done_in_rd", {31'b0, done}, 32'd0);
      tick();
    end
    RVALID   = 1'b0;
    RLAST    = 1'b0;
    RRESP    = RESP_OKAY;
    rd_ready = 1'b0;
  endtask

  task automatic checkDone(input logic expErr);
    #1;
    checkOutput("done_pulse", {31'b0, done}, 32'd1);
    checkOutput("err_flag", {31'b0, err}, {31'b0, expErr});
    checkOutput("cmd_ready_done", {31'b0, cmd_ready}, 32'd1);
  endtask

  // Run one table entry end to end and confirm done is a single-cycle pulse
  task automatic applyStimulus(input vec_t v);
    offerCmd(v.isWrite, v.addr, v.len);
    if (v.expReject) begin
      #1;
      checkOutput("AWVALID_reject", {31'b0, AWVALID}, 32'd0);
      checkOutput("ARVALID_reject", {31'b0, ARVALID}, 32'd0);
      checkDone(1'b1);
    end else begin
      addrPhase(v.isWrite, v.addr, v.len, v.addrDelay);
      if (v.isWrite) begin
        writeData(v.len, v.toggle);
        writeResp(v.bresp);
      end else begin
        readData(v.len, v.errBeat, v.lastBeat, v.toggle);
      end
      checkDone(v.expErr);
    end
    tick();
    #1;
    checkOutput("done_single", {31'b0, done}, 32'd0);
    tick();
  endtask

  // Main test sequence
  initial begin
    nCompared   = 0;
    nMismatched = 0;

    //           wr    addr          len     dly errB lastB tog  bresp        rej   err
    vecs[0] = '{1'b1, 32'h0000_1000, 8'd3,   0, -1,  3,  1'b0, RESP_OKAY,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2000, 8'd0,   3, -1,  0,  1'b0, RESP_OKAY,   1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_3000, 8'd7,   0,  5,  7,  1'b1, RESP_OKAY,   1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0FF0, 8'd7,   0, -1,  7,  1'b0, RESP_OKAY,   1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_0FE0, 8'd7,   1, -1,  7,  1'b0, RESP_OKAY,   1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0FFC, 8'd0,   0, -1,  0,  1'b0, RESP_SLVERR, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_2002, 8'd0,   0, -1,  0,  1'b0, RESP_OKAY,   1'b1, 1'b1};
    vecs[7] = '{1'b0, 32'h0000_7000, 8'd3,   0, -1,  1,  1'b0, RESP_OKAY,   1'b0, 1'b1};
    vecs[8] = '{1'b1, 32'h0000_0000, 8'd255, 2, -1,  255, 1'b1, RESP_OKAY,  1'b0, 1'b0};

    ARESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0;
    cmd_len   = 8'h0;
    wr_valid  = 1'b0;
    wr_data   = 32'h0;
    rd_ready  = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BID       = 1'b0;
    BRESP     = RESP_OKAY;
    BVALID    = 1'b0;
    ARREADY   = 1'b0;
    RID       = 1'b0;
    RDATA     = 32'h0;
    RRESP     = RESP_OKAY;
    RLAST     = 1'b0;
    RVALID    = 1'b0;

    tick();
    tick();
    tick();
    checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    checkOutput("rst_AWVALID", {31'b0, AWVALID}, 32'd0);
    checkOutput("rst_ARVALID", {31'b0, ARVALID}, 32'd0);
    checkOutput("rst_BREADY", {31'b0, BREADY}, 32'd0);
    checkOutput("rst_RREADY", {31'b0, RREADY}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_AWADDR", AWADDR, 32'h0);
    checkOutput("rst_ARLEN", {24'b0, ARLEN}, 32'h0);
    ARESETn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of a 16-beat write: everything drops, no done pulse
    offerCmd(1'b1, 32'h0000_6000, 8'd15);
    addrPhase(1'b1, 32'h0000_6000, 8'd15, 0);
    for (int b = 0; b <= 6; b++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA0 + 32'(b);
      WREADY   = 1'b1;
      #1;
      checkOutput("mid_WLAST", {31'b0, WLAST}, 32'd0);
      tick();
    end
    ARESETn = 1'b0;
    tick();
    #1;
    checkOutput("midrst_WVALID", {31'b0, WVALID}, 32'd0);
    checkOutput("midrst_wr_ready", {31'b0, wr_ready}, 32'd0);
    checkOutput("midrst_AWVALID", {31'b0, AWVALID}, 32'd0);
    checkOutput("midrst_BREADY", {31'b0, BREADY}, 32'd0);
    checkOutput("midrst_AWADDR", AWADDR, 32'h0);
    checkOutput("midrst_AWLEN", {24'b0, AWLEN}, 32'h0);
    checkOutput("midrst_done", {31'b0, done}, 32'd0);
    checkOutput("midrst_err", {31'b0, err}, 32'd0);
    ARESETn  = 1'b1;
    wr_valid = 1'b0;
    WREADY   = 1'b0;
    tick();
    #1;
    checkOutput("postrst_done", {31'b0, done}, 32'd0);
    checkOutput("postrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    applyStimulus('{1'b0, 32'h0000_8000, 8'd2, 1, -1, 2, 1'b0, RESP_OKAY, 1'b0, 1'b0});

    // Back-to-back: cmd_valid held, read accepted in the write's done cycle
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_4000;
    cmd_len   = 8'd0;
    #1;
    checkOutput("b2b_accept1", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_5000;
    cmd_len   = 8'd1;
    addrPhase(1'b1, 32'h0000_4000, 8'd0, 0);
    writeData(8'd0, 1'b0);
    writeResp(RESP_OKAY);
    checkDone(1'b0);
    tick();
    cmd_valid = 1'b0;
    addrPhase(1'b0, 32'h0000_5000, 8'd1, 0);
    readData(8'd1, -1, 1, 1'b0);
    checkDone(1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
